// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Responder side of a 4x3 (12-key) row-scan matrix keypad. A press command
//   (key index + hold length) is taken over a valid/ready handshake and played
//   out as press bounce, stable closure, release bounce and a guaranteed open
//   gap. The scanner's active-low row drive is answered on active-low column
//   lines, including the contact bounce.
//
// Ports
//   int_osc    in   system clock
//   reset      in   asynchronous, active-high reset
//   cmd_valid  in   press command valid
//   cmd_ready  out  command can be accepted (high only in idle)
//   cmd_key    in   key index 0..11 (row = key/3, col = key%3)
//   cmd_hold   in   clocks of stable closure after press bounce (0 acts as 1)
//   row_drive  in   scanner row lines, active-low, 4'b1111 = no drive
//   col        out  column lines, active-low, idle-high
//   pressed    out  high only during stable closure
//   busy       out  high whenever not idle
//   done       out  one-clock pulse when a command completes
//   cmd_err    out  one-clock pulse when an out-of-range key is accepted
module keypad_emulator #(
    parameter int unsigned BOUNCE_CYCLES = 24000,
    parameter int unsigned BOUNCE_PERIOD = 64,
    parameter int unsigned MIN_GAP       = 48000,
    parameter int unsigned HOLD_W        = 24
) (
    input  logic              int_osc,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [3:0]        row_drive,
    output logic [2:0]        col,
    output logic              pressed,
    output logic              busy,
    output logic              done,
    output logic              cmd_err
);

    // One shared in-state counter; sized for the largest interval plus a spare bit.
    localparam int unsigned BounceBits = $clog2(BOUNCE_CYCLES + 1);
    localparam int unsigned GapBits    = $clog2(MIN_GAP + 1);
    localparam int unsigned MaxBits    = (HOLD_W > BounceBits) ?
                                         ((HOLD_W > GapBits) ? HOLD_W : GapBits) :
                                         ((BounceBits > GapBits) ? BounceBits : GapBits);
    localparam int unsigned CntW       = MaxBits + 1;
    localparam int unsigned PerW       = $clog2(BOUNCE_PERIOD) + 1;

    localparam logic [CntW-1:0] BounceLast =
        CntW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CntW-1:0] GapLast    = CntW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
    localparam logic [PerW-1:0] PerLast    =
        PerW'((BOUNCE_PERIOD > 0) ? BOUNCE_PERIOD - 1 : 0);
    localparam logic            NoBounce   = (BOUNCE_CYCLES == 0);

    typedef enum logic [2:0] {
        StIdle,
        StPressBounce,
        StHeld,
        StReleaseBounce,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic              contact_q, contact_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PerW-1:0]   per_q, per_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [1:0]        row_q, row_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [HOLD_W-1:0] hold_last_q, hold_last_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [15:0]       lfsr_step;
    logic [1:0]        key_row;
    logic [1:0]        key_col;

    // Fibonacci LFSR for x^16 + x^14 + x^13 + x^11 + 1.
    assign lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    // Key index to matrix position; out-of-range keys never reach the lines.
    always_comb begin
        key_row = 2'd0;
        key_col = 2'd0;
        unique case (cmd_key)
            4'd0:    begin key_row = 2'd0; key_col = 2'd0; end
            4'd1:    begin key_row = 2'd0; key_col = 2'd1; end
            4'd2:    begin key_row = 2'd0; key_col = 2'd2; end
            4'd3:    begin key_row = 2'd1; key_col = 2'd0; end
            4'd4:    begin key_row = 2'd1; key_col = 2'd1; end
            4'd5:    begin key_row = 2'd1; key_col = 2'd2; end
            4'd6:    begin key_row = 2'd2; key_col = 2'd0; end
            4'd7:    begin key_row = 2'd2; key_col = 2'd1; end
            4'd8:    begin key_row = 2'd2; key_col = 2'd2; end
            4'd9:    begin key_row = 2'd3; key_col = 2'd0; end
            4'd10:   begin key_row = 2'd3; key_col = 2'd1; end
            4'd11:   begin key_row = 2'd3; key_col = 2'd2; end
            default: begin key_row = 2'd0; key_col = 2'd0; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        contact_d   = contact_q;
        cnt_d       = cnt_q + CntW'(1);
        per_d       = per_q;
        lfsr_d      = lfsr_q;
        row_d       = row_q;
        col_idx_d   = col_idx_q;
        hold_last_d = hold_last_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        // Bounce windows: periodic pseudo-random contact. A state transition
        // below overrides the contact value on the exit edge.
        if (state_q == StPressBounce || state_q == StReleaseBounce) begin
            if (per_q == PerLast) begin
                per_d     = '0;
                lfsr_d    = lfsr_step;
                contact_d = lfsr_step[0];
            end else begin
                per_d = per_q + PerW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                contact_d = 1'b0;
                cnt_d     = '0;
                if (cmd_valid) begin
                    if (cmd_key <= 4'd11) begin
                        row_d       = key_row;
                        col_idx_d   = key_col;
                        hold_last_d = (cmd_hold == '0) ? '0 : cmd_hold - HOLD_W'(1);
                        per_d       = '0;
                        contact_d   = 1'b1;
                        state_d     = NoBounce ? StHeld : StPressBounce;
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            StPressBounce: begin
                if (cnt_q == BounceLast) begin
                    state_d   = StHeld;
                    cnt_d     = '0;
                    contact_d = 1'b1;
                end
            end
            StHeld: begin
                contact_d = 1'b1;
                if (cnt_q == CntW'(hold_last_q)) begin
                    state_d   = NoBounce ? StGap : StReleaseBounce;
                    cnt_d     = '0;
                    per_d     = '0;
                    contact_d = 1'b0;
                end
            end
            StReleaseBounce: begin
                if (cnt_q == BounceLast) begin
                    state_d   = StGap;
                    cnt_d     = '0;
                    contact_d = 1'b0;
                end
            end
            StGap: begin
                contact_d = 1'b0;
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                contact_d = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            contact_q   <= 1'b0;
            cnt_q       <= '0;
            per_q       <= '0;
            lfsr_q      <= 16'hACE1;
            row_q       <= 2'd0;
            col_idx_q   <= 2'd0;
            hold_last_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            contact_q   <= contact_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            lfsr_q      <= lfsr_d;
            row_q       <= row_d;
            col_idx_q   <= col_idx_d;
            hold_last_q <= hold_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Column response is combinational on the row drive, like a real contact.
    always_comb begin
        col = 3'b111;
        if (contact_q && !row_drive[row_q]) begin
            col[col_idx_q] = 1'b0;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign pressed   = (state_q == StHeld);
    assign done      = done_q;
    assign cmd_err   = err_q;

endmodule
